regfile_sched: RTL

Issue and writeback controller for the DLX pipeline's register file (three read ports, one combinational write port). It tracks registers with an outstanding long-latency write (load/mul/div) in a busy scoreboard and stalls issue on RAW/WAW hazards. It also arbitrates the single write port between the fixed-latency ALU writeback and the long-latency unit, with anti-starvation aging.

---
 rtl/dlx_sched_pkg.sv | 25 ++
 rtl/sched_wb_arb.sv | 76 +++++++
 rtl/regfile_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dlx_sched_pkg.sv
// Shared types and constants for the DLX register-file issue/writeback scheduler.
package dlx_sched_pkg;

  localparam int REG_W = 5;
  localparam int NREGS = 32;

  typedef enum logic {
    ARB_NORM  = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [31:0]      data;
  } wb_req_t;

  function automatic logic [NREGS-1:0] reg_mask(input logic [REG_W-1:0] r);
    logic [NREGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/sched_wb_arb.sv
// Write-port arbiter: ALU has priority, a long-unit request denied STARVE_LIMIT
// times in a row gets one forced cycle. Drives the register-file write port.
module sched_wb_arb
  import dlx_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  wb_req_t          alu_req,
  input  wb_req_t          long_req,
  output logic             alu_hold,
  output logic             long_ready,
  output logic             force_enter,
  output arb_state_t       state,
  output logic [REG_W-1:0] rf_rd,
  output logic [31:0]      rf_wdata
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [AGE_W-1:0] age;
  logic             alu_grant;
  logic             long_denied;

  // Handshake: a request is taken in the cycle its valid is high and the grant
  // (long_ready, or !alu_hold for the ALU) is high; otherwise it is re-presented.
  always_comb begin
    long_ready  = long_req.valid & ((state == ARB_FORCE) | ~alu_req.valid);
    alu_grant   = alu_req.valid & (state == ARB_NORM);
    alu_hold    = alu_req.valid & (state == ARB_FORCE);
    long_denied = long_req.valid & ~long_ready;
    force_enter = (state == ARB_NORM) & long_denied &
                  (age == AGE_W'(STARVE_LIMIT - 1));
  end

  always_comb begin
    rf_rd    = '0;
    rf_wdata = '0;
    if (long_ready) begin
      rf_rd    = long_req.rd;
      rf_wdata = long_req.data;
    end else if (alu_grant) begin
      rf_rd    = alu_req.rd;
      rf_wdata = alu_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_NORM;
      age   <= '0;
    end else begin
      case (state)
        ARB_NORM: begin
          if (force_enter) begin
            state <= ARB_FORCE;
          end else if (long_denied) begin
            age <= age + AGE_W'(1);
          end else begin
            age <= '0;
          end
        end
        ARB_FORCE: begin
          state <= ARB_NORM;
          age   <= '0;
        end
        default: begin
          state <= ARB_NORM;
          age   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_sched.sv
// Register-file issue/writeback controller: busy scoreboard, RAW/WAW stall and
// write-port arbitration. Define REGFILE_SCHED_STATS_EN for stall/force counters.
module regfile_sched
  import dlx_sched_pkg::*;
#(
  parameter int LONG_MAX     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_rs1,
  input  logic [REG_W-1:0] iss_rs2,
  input  logic [REG_W-1:0] iss_rs3,
  input  logic [REG_W-1:0] iss_rd,
  input  logic             iss_wr,
  input  logic             iss_long,
  output logic             iss_stall,
  input  logic             wb_alu_valid,
  input  logic [REG_W-1:0] wb_alu_rd,
  input  logic [31:0]      wb_alu_data,
  output logic             alu_hold,
  input  logic             wb_long_valid,
  input  logic [REG_W-1:0] wb_long_rd,
  input  logic [31:0]      wb_long_data,
  output logic             wb_long_ready,
`ifdef REGFILE_SCHED_STATS_EN
  output logic [31:0]      stat_stall,
  output logic [31:0]      stat_force,
`endif
  output logic [REG_W-1:0] rf_rd,
  output logic [31:0]      rf_wdata
);

  localparam int CNT_W = $clog2(LONG_MAX + 1);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] effbusy;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;
  logic [CNT_W-1:0] outstanding;
  logic             long_accept;
  logic             long_issue;
  logic             cnt_full;
  logic             force_enter;
  arb_state_t       arb_state;
  wb_req_t          alu_req;
  wb_req_t          long_req;

  assign alu_req  = '{valid: wb_alu_valid,  rd: wb_alu_rd,  data: wb_alu_data};
  assign long_req = '{valid: wb_long_valid, rd: wb_long_rd, data: wb_long_data};

  sched_wb_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .alu_req    (alu_req),
    .long_req   (long_req),
    .alu_hold   (alu_hold),
    .long_ready (wb_long_ready),
    .force_enter(force_enter),
    .state      (arb_state),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata)
  );

  // The register file forwards the write data, so a register retiring its
  // long write this cycle is already readable.
  always_comb begin
    long_accept = wb_long_ready;
    clr_mask    = long_accept ? reg_mask(wb_long_rd) : '0;
    effbusy     = busy & ~clr_mask;
    cnt_full    = (outstanding == CNT_W'(LONG_MAX));
    iss_stall   = iss_valid & (effbusy[iss_rs1] | effbusy[iss_rs2] | effbusy[iss_rs3] |
                               (iss_wr & effbusy[iss_rd]) |
                               (iss_long & iss_wr & cnt_full & ~long_accept));
    long_issue  = iss_valid & iss_wr & iss_long & ~iss_stall & (iss_rd != '0);
    set_mask    = long_issue ? reg_mask(iss_rd) : '0;
  end

  // Set is applied after clear so a same-register issue/retire leaves it busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      busy <= (effbusy | set_mask) & ~NREGS'(1);
      case ({long_issue, long_accept})
        2'b10: if (!cnt_full) outstanding <= outstanding + CNT_W'(1);
        2'b01: if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef REGFILE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall <= '0;
      stat_force <= '0;
    end else begin
      if (iss_stall && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
      if (force_enter && stat_force != '1) stat_force <= stat_force + 32'd1;
    end
  end
`endif

  a_long_wb_busy: assert property (@(posedge clk) disable iff (rst)
    long_accept |-> busy[wb_long_rd]);

  a_alu_wb_free: assert property (@(posedge clk) disable iff (rst)
    (wb_alu_valid && !alu_hold && wb_alu_rd != '0) |-> !busy[wb_alu_rd]);

  a_hold_only_forced: assert property (@(posedge clk) disable iff (rst)
    alu_hold |-> (arb_state == ARB_FORCE));

  a_force_on_conflict: assert property (@(posedge clk) disable iff (rst)
    force_enter |-> (wb_long_valid && wb_alu_valid));

endmodule
